// File: rtl/sm3_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sm3_pkg
//  Description : Shared SM3 constants, controller state encoding and the
//                word-level helper functions used by the compression core.
//  Revision    : 1.0
// ============================================================================
package sm3_pkg;

    localparam int SM3_BLK_W = 512;
    localparam int SM3_DIG_W = 256;

    localparam logic [SM3_DIG_W-1:0] SM3_IV =
        256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_OUT  = 2'd3
    } ctrl_state_t;

    // Rotation through a doubled word keeps the shift amount free of the
    // zero-rotate special case.
    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] d;
        d = {x, x} << n;
        return d[63:32];
    endfunction

    function automatic logic [31:0] sm3_p0(input logic [31:0] x);
        return x ^ rotl32(x, 5'd9) ^ rotl32(x, 5'd17);
    endfunction

    function automatic logic [31:0] sm3_p1(input logic [31:0] x);
        return x ^ rotl32(x, 5'd15) ^ rotl32(x, 5'd23);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sm3_hash_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : sm3_hash_ctrl_if
//  Description : Block-in / digest-out handshake bundle of the SM3 sequencer.
//  Revision    : 1.0
// ============================================================================
interface sm3_hash_ctrl_if;
    import sm3_pkg::*;

    logic                 blk_valid;
    logic                 blk_ready;
    logic [SM3_BLK_W-1:0] blk_data;
    logic                 blk_last;
    logic                 hash_valid;
    logic                 hash_ready;
    logic [SM3_DIG_W-1:0] hash_out;

    modport master (
        output blk_valid, blk_data, blk_last, hash_ready,
        input  blk_ready, hash_valid, hash_out
    );

    modport slave (
        input  blk_valid, blk_data, blk_last, hash_ready,
        output blk_ready, hash_valid, hash_out
    );

endinterface
`default_nettype wire

// File: rtl/sm3_hash_ctrl_cf.sv
`default_nettype none
// ============================================================================
//  Module      : sm3_hash_ctrl_cf
//  Description : Iterative SM3 compression function, one round per cycle
//                with a 16-word sliding message-expansion window.
//  Revision    : 1.0
// ============================================================================
module sm3_hash_ctrl_cf
    import sm3_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SM3_DIG_W-1:0] V_in,
    input  logic [SM3_BLK_W-1:0] B,
    output logic                 done,
    output logic [SM3_DIG_W-1:0] V_out
);

    logic        r_started;
    logic        r_done;
    logic [5:0]  r_j;
    logic [31:0] r_st [8];
    logic [31:0] r_w  [16];

    logic        w_low;
    logic [31:0] w_t;
    logic [31:0] w_a12;
    logic [31:0] w_ss1;
    logic [31:0] w_ss2;
    logic [31:0] w_ff;
    logic [31:0] w_gg;
    logic [31:0] w_tt1;
    logic [31:0] w_tt2;
    logic [31:0] w_w_new;

    assign w_low = (r_j[5:4] == 2'b00);
    assign w_t   = w_low ? 32'h79cc4519 : 32'h7a879d8a;
    assign w_a12 = rotl32(r_st[0], 5'd12);
    assign w_ss1 = rotl32(w_a12 + r_st[4] + rotl32(w_t, r_j[4:0]), 5'd7);
    assign w_ss2 = w_ss1 ^ w_a12;
    assign w_ff  = w_low ? (r_st[0] ^ r_st[1] ^ r_st[2])
                         : ((r_st[0] & r_st[1]) | (r_st[0] & r_st[2]) | (r_st[1] & r_st[2]));
    assign w_gg  = w_low ? (r_st[4] ^ r_st[5] ^ r_st[6])
                         : ((r_st[4] & r_st[5]) | (~r_st[4] & r_st[6]));
    assign w_tt1 = w_ff + r_st[3] + w_ss2 + (r_w[0] ^ r_w[4]);
    assign w_tt2 = w_gg + r_st[7] + w_ss1 + r_w[0];

    // Window slot k holds W[j+k]; the new word is W[j+16].
    assign w_w_new = sm3_p1(r_w[0] ^ r_w[7] ^ rotl32(r_w[13], 5'd15))
                   ^ rotl32(r_w[3], 5'd7) ^ r_w[10];

    // The first cycle out of reset captures the operands; 64 rounds follow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_started <= 1'b0;
            r_done    <= 1'b0;
            r_j       <= '0;
            for (int i = 0; i < 8; i++)  r_st[i] <= '0;
            for (int i = 0; i < 16; i++) r_w[i]  <= '0;
        end else if (!r_started) begin
            r_started <= 1'b1;
            r_j       <= '0;
            for (int i = 0; i < 8; i++)  r_st[i] <= V_in[SM3_DIG_W-1-32*i -: 32];
            for (int i = 0; i < 16; i++) r_w[i]  <= B[SM3_BLK_W-1-32*i -: 32];
        end else if (!r_done) begin
            r_st[0] <= w_tt1;
            r_st[1] <= r_st[0];
            r_st[2] <= rotl32(r_st[1], 5'd9);
            r_st[3] <= r_st[2];
            r_st[4] <= sm3_p0(w_tt2);
            r_st[5] <= r_st[4];
            r_st[6] <= rotl32(r_st[5], 5'd19);
            r_st[7] <= r_st[6];
            for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
            r_w[15] <= w_w_new;
            r_j     <= r_j + 6'd1;
            if (r_j == 6'd63) r_done <= 1'b1;
        end
    end

    assign done = r_done;

    for (genvar g = 0; g < 8; g++) begin : g_vout
        assign V_out[SM3_DIG_W-1-32*g -: 32] = r_st[g] ^ V_in[SM3_DIG_W-1-32*g -: 32];
    end

endmodule
`default_nettype wire

// File: rtl/sm3_hash_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sm3_hash_ctrl
//  Description : Sequences padded blocks through one SM3 CF core, chains the
//                results from the IV and hands out the final digest.
//  Revision    : 1.0
// ============================================================================
module sm3_hash_ctrl
    import sm3_pkg::*;
#(
    parameter logic [SM3_DIG_W-1:0] IV      = SM3_IV,
    parameter int unsigned          TIMEOUT = 1024
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           abort,
    sm3_hash_ctrl_if.slave bus,
    output logic           busy,
    output logic [31:0]    blk_cnt,
    output logic           err
);

    localparam int              TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    ctrl_state_t          r_state;
    ctrl_state_t          w_state_nxt;

    logic [SM3_DIG_W-1:0] r_v;
    logic [SM3_BLK_W-1:0] r_b;
    logic                 r_last;
    logic [TMO_W-1:0]     r_tmo;
    logic [31:0]          r_cnt;
    logic                 r_err;
    logic                 r_cf_rst_n;

    logic                 w_accept;
    logic                 w_finish;
    logic                 w_timeout;
    logic                 w_release;
    logic                 w_cf_rst_n;
    logic                 w_cf_done;
    logic [SM3_DIG_W-1:0] w_cf_v_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Abort overrides every event, including a simultaneous CF completion.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_finish    = 1'b0;
        w_timeout   = 1'b0;
        w_release   = 1'b0;
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.blk_valid) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_LOAD;
                    end
                end
                ST_LOAD: w_state_nxt = ST_RUN;
                ST_RUN: begin
                    if (w_cf_done) begin
                        w_finish    = 1'b1;
                        w_state_nxt = r_last ? ST_OUT : ST_IDLE;
                    end else if (r_tmo == TMO_LAST) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_OUT: begin
                    if (bus.hash_ready) begin
                        w_release   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v        <= IV;
            r_b        <= '0;
            r_last     <= 1'b0;
            r_tmo      <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_cf_rst_n <= 1'b0;
        end else begin
            // CF runs exactly while the controller sits in RUN.
            r_cf_rst_n <= (w_state_nxt == ST_RUN);
            if (abort) begin
                r_v   <= IV;
                r_cnt <= '0;
                r_err <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_b    <= bus.blk_data;
                    r_last <= bus.blk_last;
                end
                if (r_state == ST_LOAD)     r_tmo <= '0;
                else if (r_state == ST_RUN) r_tmo <= r_tmo + 1'b1;
                if (w_finish) begin
                    r_v   <= w_cf_v_out;
                    r_cnt <= r_cnt + 32'd1;
                end
                if (w_timeout) begin
                    r_err <= 1'b1;
                    r_v   <= IV;
                    r_cnt <= '0;
                end
                if (w_release) begin
                    r_v   <= IV;
                    r_cnt <= '0;
                end
            end
        end
    end

    assign w_cf_rst_n = r_cf_rst_n & rst_n;

    sm3_hash_ctrl_cf u_cf (
        .clk   (clk),
        .rst_n (w_cf_rst_n),
        .V_in  (r_v),
        .B     (r_b),
        .done  (w_cf_done),
        .V_out (w_cf_v_out)
    );

    assign bus.blk_ready  = (r_state == ST_IDLE);
    assign bus.hash_valid = (r_state == ST_OUT);
    assign bus.hash_out   = r_v;
    assign busy           = (r_state != ST_IDLE);
    assign blk_cnt        = r_cnt;
    assign err            = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sm3_hash_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sm3_hash_ctrl
//  Description : Self-checking bench for the SM3 block sequencer.
//  Revision    : 1.0
// ============================================================================
module tb_sm3_hash_ctrl;
    import sm3_pkg::*;

    localparam int unsigned TO2 = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic abort, abort2;
    logic busy, busy2, err, err2;
    logic [31:0] blk_cnt, blk_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    sm3_hash_ctrl_if bus();
    sm3_hash_ctrl_if bus2();

    sm3_hash_ctrl dut (
        .clk(clk), .rst_n(rst_n), .abort(abort), .bus(bus),
        .busy(busy), .blk_cnt(blk_cnt), .err(err)
    );

    sm3_hash_ctrl #(.TIMEOUT(TO2)) dut2 (
        .clk(clk), .rst_n(rst_n), .abort(abort2), .bus(bus2),
        .busy(busy2), .blk_cnt(blk_cnt2), .err(err2)
    );

    always #5 clk = ~clk;

    localparam logic [511:0] BLK_ABC  = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_ABCD = {16{32'h61626364}};
    localparam logic [511:0] BLK_PAD2 = {32'h80000000, 448'h0, 32'h00000200};
    localparam logic [255:0] DIG_ABC  =
        256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
    localparam logic [255:0] DIG_2BLK =
        256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;

    // ---------------- reference model: textbook SM3 compression ----------------
    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        int k;
        k = n % 32;
        if (k == 0) return x;
        return (x << k) | (x >> (32 - k));
    endfunction

    function automatic logic [255:0] ref_cf(input logic [255:0] v, input logic [511:0] blk);
        logic [31:0] w [68];
        logic [31:0] wp [64];
        logic [31:0] a, b, c, d, e, f, g, h, t, ss1, ss2, tt1, tt2, x;
        for (int j = 0; j < 16; j++) w[j] = blk[511-32*j -: 32];
        for (int j = 16; j < 68; j++) begin
            x    = w[j-16] ^ w[j-9] ^ rl(w[j-3], 15);
            w[j] = (x ^ rl(x, 15) ^ rl(x, 23)) ^ rl(w[j-13], 7) ^ w[j-6];
        end
        for (int j = 0; j < 64; j++) wp[j] = w[j] ^ w[j+4];
        {a, b, c, d, e, f, g, h} = v;
        for (int j = 0; j < 64; j++) begin
            t   = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
            ss1 = rl(rl(a, 12) + e + rl(t, j), 7);
            ss2 = ss1 ^ rl(a, 12);
            if (j < 16) begin
                tt1 = (a ^ b ^ c) + d + ss2 + wp[j];
                tt2 = (e ^ f ^ g) + h + ss1 + w[j];
            end else begin
                tt1 = ((a & b) | (a & c) | (b & c)) + d + ss2 + wp[j];
                tt2 = ((e & f) | (~e & g)) + h + ss1 + w[j];
            end
            d = c; c = rl(b, 9); b = a; a = tt1;
            h = g; g = rl(f, 19); f = e;
            e = tt2 ^ rl(tt2, 9) ^ rl(tt2, 17);
        end
        return {a, b, c, d, e, f, g, h} ^ v;
    endfunction

    // ---------------- stimulus helpers (bounded waits) ----------------
    task automatic drive_block(input logic [511:0] data, input logic last);
        int n;
        @(negedge clk);
        bus.blk_valid = 1'b1; bus.blk_data = data; bus.blk_last = last;
        n = 0;
        while (bus.blk_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        n_checks++;
        if (bus.blk_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL drive_block: blk_ready=%b after %0d cycles, required 1", bus.blk_ready, n);
        end
        @(negedge clk);
        bus.blk_valid = 1'b0;
    endtask

    task automatic wait_hash(input string tag);
        int n;
        n = 0;
        while (bus.hash_valid !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        n_checks++;
        if (bus.hash_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s wait: hash_valid=%b after %0d cycles, required 1", tag, bus.hash_valid, n);
        end
    endtask

    task automatic handshake();
        @(negedge clk); bus.hash_ready = 1'b1;
        @(negedge clk); bus.hash_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks += 7;
        if (bus.blk_ready !== 1'b1)  begin n_fail++; $display("FAIL reset blk_ready: got %b want 1", bus.blk_ready); end
        if (bus.hash_valid !== 1'b0) begin n_fail++; $display("FAIL reset hash_valid: got %b want 0", bus.hash_valid); end
        if (busy !== 1'b0)           begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
        if (bus.hash_out !== SM3_IV) begin n_fail++; $display("FAIL reset hash_out: got %h want %h", bus.hash_out, SM3_IV); end
        if (blk_cnt !== 32'd0)       begin n_fail++; $display("FAIL reset blk_cnt: got %0d want 0", blk_cnt); end
        if (err !== 1'b0)            begin n_fail++; $display("FAIL reset err: got %b want 0", err); end
        if (err2 !== 1'b0)           begin n_fail++; $display("FAIL reset err2: got %b want 0", err2); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_abc();
        drive_block(BLK_ABC, 1'b1);
        wait_hash("abc");
        n_checks += 3;
        if (bus.hash_out !== DIG_ABC) begin n_fail++; $display("FAIL abc digest: got %h want %h", bus.hash_out, DIG_ABC); end
        if (ref_cf(SM3_IV, BLK_ABC) !== bus.hash_out) begin n_fail++; $display("FAIL abc model: got %h want %h", bus.hash_out, ref_cf(SM3_IV, BLK_ABC)); end
        if (blk_cnt !== 32'd1) begin n_fail++; $display("FAIL abc blk_cnt: got %0d want 1", blk_cnt); end
        handshake();
        n_checks += 4;
        if (bus.blk_ready !== 1'b1)  begin n_fail++; $display("FAIL abc post blk_ready: got %b want 1", bus.blk_ready); end
        if (bus.hash_valid !== 1'b0) begin n_fail++; $display("FAIL abc post hash_valid: got %b want 0", bus.hash_valid); end
        if (blk_cnt !== 32'd0)       begin n_fail++; $display("FAIL abc post blk_cnt: got %0d want 0", blk_cnt); end
        if (bus.hash_out !== SM3_IV) begin n_fail++; $display("FAIL abc post hash_out: got %h want %h", bus.hash_out, SM3_IV); end
    endtask

    task automatic test_two_block(input int gap);
        int n;
        drive_block(BLK_ABCD, 1'b0);
        if (gap > 0) begin
            n = 0;
            while (bus.blk_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
            repeat (gap) @(negedge clk);
        end
        drive_block(BLK_PAD2, 1'b1);
        n_checks++;
        if (blk_cnt !== 32'd1) begin n_fail++; $display("FAIL two_block mid blk_cnt (gap %0d): got %0d want 1", gap, blk_cnt); end
        wait_hash("two_block");
        n_checks += 2;
        if (bus.hash_out !== DIG_2BLK) begin n_fail++; $display("FAIL two_block digest (gap %0d): got %h want %h", gap, bus.hash_out, DIG_2BLK); end
        if (blk_cnt !== 32'd2) begin n_fail++; $display("FAIL two_block blk_cnt (gap %0d): got %0d want 2", gap, blk_cnt); end
        handshake();
    endtask

    task automatic test_backpressure();
        int bad;
        drive_block(BLK_ABC, 1'b1);
        wait_hash("backpressure");
        bad = 0;
        bus.blk_valid = 1'b1; bus.blk_data = {16{32'hdeadbeef}}; bus.blk_last = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.hash_out !== DIG_ABC || bus.blk_ready !== 1'b0 || bus.hash_valid !== 1'b1) bad++;
        end
        bus.blk_valid = 1'b0;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL backpressure hold: %0d of 20 cycles unstable, required 0", bad); end
        handshake();
        drive_block(BLK_ABC, 1'b1);
        wait_hash("backpressure_rerun");
        n_checks++;
        if (bus.hash_out !== DIG_ABC) begin n_fail++; $display("FAIL backpressure rerun digest: got %h want %h", bus.hash_out, DIG_ABC); end
        handshake();
    endtask

    task automatic test_abort();
        int seen;
        drive_block(BLK_ABCD, 1'b0);
        repeat (8) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL abort pre busy: got %b want 1", busy); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks += 4;
        if (busy !== 1'b0)           begin n_fail++; $display("FAIL abort busy: got %b want 0", busy); end
        if (bus.blk_ready !== 1'b1)  begin n_fail++; $display("FAIL abort blk_ready: got %b want 1", bus.blk_ready); end
        if (blk_cnt !== 32'd0)       begin n_fail++; $display("FAIL abort blk_cnt: got %0d want 0", blk_cnt); end
        if (bus.hash_out !== SM3_IV) begin n_fail++; $display("FAIL abort hash_out: got %h want %h", bus.hash_out, SM3_IV); end
        seen = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (bus.hash_valid === 1'b1 || busy === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin n_fail++; $display("FAIL abort quiet: %0d active cycles, required 0", seen); end
        drive_block(BLK_ABC, 1'b1);
        wait_hash("abort_rerun");
        n_checks++;
        if (bus.hash_out !== DIG_ABC) begin n_fail++; $display("FAIL abort rerun digest: got %h want %h", bus.hash_out, DIG_ABC); end
        handshake();
    endtask

    task automatic test_abort_on_done();
        int n;
        drive_block(BLK_ABC, 1'b1);
        n = 0;
        while (dut.w_cf_done !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks += 4;
        if (bus.hash_valid !== 1'b0) begin n_fail++; $display("FAIL abort_done hash_valid: got %b want 0", bus.hash_valid); end
        if (busy !== 1'b0)           begin n_fail++; $display("FAIL abort_done busy: got %b want 0", busy); end
        if (blk_cnt !== 32'd0)       begin n_fail++; $display("FAIL abort_done blk_cnt: got %0d want 0", blk_cnt); end
        if (bus.hash_out !== SM3_IV) begin n_fail++; $display("FAIL abort_done hash_out: got %h want %h", bus.hash_out, SM3_IV); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        int n;
        @(negedge clk);
        bus2.blk_valid = 1'b1; bus2.blk_data = BLK_ABC; bus2.blk_last = 1'b1;
        @(negedge clk);
        bus2.blk_valid = 1'b0;
        n = 1;
        while (err2 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        n_checks += 5;
        if (n != 2 + int'(TO2)) begin n_fail++; $display("FAIL timeout latency: err after %0d edges, required %0d", n, 2 + TO2); end
        if (busy2 !== 1'b0)           begin n_fail++; $display("FAIL timeout busy: got %b want 0", busy2); end
        if (bus2.hash_valid !== 1'b0) begin n_fail++; $display("FAIL timeout hash_valid: got %b want 0", bus2.hash_valid); end
        if (bus2.hash_out !== SM3_IV) begin n_fail++; $display("FAIL timeout hash_out: got %h want %h", bus2.hash_out, SM3_IV); end
        if (blk_cnt2 !== 32'd0)       begin n_fail++; $display("FAIL timeout blk_cnt: got %0d want 0", blk_cnt2); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (err2 !== 1'b1) begin n_fail++; $display("FAIL timeout sticky err: got %b want 1", err2); end
        abort2 = 1'b1;
        @(negedge clk);
        abort2 = 1'b0;
        n_checks++;
        if (err2 !== 1'b0) begin n_fail++; $display("FAIL timeout abort clears err: got %b want 0", err2); end
    endtask

    task automatic test_reset_mid_run();
        drive_block(BLK_ABCD, 1'b0);
        drive_block(BLK_PAD2, 1'b1);
        repeat (5) @(negedge clk);
        n_checks++;
        if (blk_cnt !== 32'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL midrun pre: blk_cnt=%0d busy=%b want 1/1", blk_cnt, busy); end
        #2 rst_n = 1'b0;
        #1;
        n_checks += 5;
        if (bus.blk_ready !== 1'b1)  begin n_fail++; $display("FAIL midrun blk_ready: got %b want 1", bus.blk_ready); end
        if (bus.hash_valid !== 1'b0) begin n_fail++; $display("FAIL midrun hash_valid: got %b want 0", bus.hash_valid); end
        if (busy !== 1'b0)           begin n_fail++; $display("FAIL midrun busy: got %b want 0", busy); end
        if (bus.hash_out !== SM3_IV) begin n_fail++; $display("FAIL midrun hash_out: got %h want %h", bus.hash_out, SM3_IV); end
        if (blk_cnt !== 32'd0)       begin n_fail++; $display("FAIL midrun blk_cnt: got %0d want 0", blk_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [511:0] data;
        logic [255:0] exp;
        int nb;
        for (int m = 0; m < 6; m++) begin
            nb  = int'($urandom_range(1, 3));
            exp = SM3_IV;
            for (int k = 0; k < nb; k++) begin
                for (int i = 0; i < 16; i++) data[32*i +: 32] = $urandom();
                repeat ($urandom_range(0, 5)) @(negedge clk);
                drive_block(data, (k == nb - 1));
                exp = ref_cf(exp, data);
            end
            wait_hash("random");
            n_checks += 2;
            if (bus.hash_out !== exp) begin n_fail++; $display("FAIL random msg %0d digest: got %h want %h", m, bus.hash_out, exp); end
            if (blk_cnt !== 32'(nb))  begin n_fail++; $display("FAIL random msg %0d blk_cnt: got %0d want %0d", m, blk_cnt, nb); end
            repeat ($urandom_range(0, 4)) @(negedge clk);
            handshake();
        end
    endtask

    initial begin
        abort = 1'b0; abort2 = 1'b0;
        bus.blk_valid = 1'b0; bus.blk_data = '0; bus.blk_last = 1'b0; bus.hash_ready = 1'b0;
        bus2.blk_valid = 1'b0; bus2.blk_data = '0; bus2.blk_last = 1'b0; bus2.hash_ready = 1'b0;
        test_reset();
        test_single_abc();
        test_two_block(0);
        test_backpressure();
        test_two_block(15);
        test_abort();
        test_abort_on_done();
        test_timeout();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/sm3_hash_ctrl.md
# sm3_hash_ctrl

Sequencer for the SM3 compression function `CF`. It accepts pre-padded 512-bit message blocks over a valid/ready handshake and restarts a single `CF` instance once per block. It chains each block's output into the next block's `V_in`, starting from the SM3 IV, and presents the final 256-bit digest over a second handshake. It sits between the padding front-end and the hash result consumer, and owns the only `CF` instance.

## Interface
- `IV`, default 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e. Initial chaining value.
- `TIMEOUT`, default 1024. Maximum RUN cycles before `err` is raised.
- `clk` input 1. Single clock, rising edge.
- `rst_n` input 1. Asynchronous, active-low reset.
- `abort` input 1. Synchronous clear to the fresh-message state.
- `blk_valid` input 1. Block offered.
- `blk_ready` output 1. Block can be accepted.
- `blk_data` input 512. Padded block, big-endian word order, same layout as `CF.B`.
- `blk_last` input 1. Marks the final block of the message; sampled with `blk_data`.
- `hash_valid` output 1. Digest available.
- `hash_ready` input 1. Consumer takes the digest.
- `hash_out` output 256. Digest; equals the chaining register.
- `busy` output 1. High whenever state ≠ IDLE.
- `blk_cnt` output 32. Blocks compressed since the last IV load; wraps modulo 2^32.
- `err` output 1. Sticky `CF` timeout flag.

## Operation
- `CF` contract:
  - `CF` starts compressing on the first cycle its `rst_n` is high.
  - `V_in` and `B` must be stable from one cycle before release until `done`.
  - `done` is a level signal; it stays high with `V_out` valid until `CF` is reset again.
  - `CF` latency is unspecified; the controller only waits on `done`.
- Registers:
  - `v_reg` (256), `b_reg` (512), `last_reg`, `tmo_cnt`.
  - `cf_rst_n` is a flop, asynchronously cleared by `rst_n`; it is 1 exactly during RUN cycles.
  - `CF` is therefore held in reset in every other state.
- FSM states: IDLE, LOAD, RUN, OUT.
  - IDLE: `blk_ready`=1.
    - On `blk_valid`: `b_reg`←`blk_data`, `last_reg`←`blk_last`, go to LOAD.
  - LOAD: `b_reg` and `v_reg` drive `CF`. `cf_rst_n` is still 0. Next state is RUN, and `cf_rst_n` becomes 1 on that edge.
  - RUN: `tmo_cnt` increments every cycle.
    - On `cf_done`: `v_reg`←`cf_V_out`, `blk_cnt`+1, `cf_rst_n`←0. Next state is OUT if `last_reg`, else IDLE (chained `v_reg` is kept).
    - If `tmo_cnt` reaches `TIMEOUT`−1 without `cf_done`: `err`←1, `v_reg`←`IV`, `blk_cnt`←0, go to IDLE.
  - OUT: `hash_valid`=1 and `hash_out` is held stable.
    - On `hash_ready`: `v_reg`←`IV`, `blk_cnt`←0, go to IDLE.
- `abort`, in any state:
  - Next state IDLE, `v_reg`←`IV`, `blk_cnt`←0, `err`←0, `cf_rst_n`←0.
  - Takes priority over every other event in the same cycle, including `cf_done` and `hash_ready`.
- `blk_valid` is ignored outside IDLE; `blk_ready` is 0 there.
- `blk_ready` does not depend combinationally on `hash_ready`.
- A new block cannot enter while OUT is pending; the digest must be consumed first.

## Timing
- Reset values:
  - State IDLE, `blk_ready`=1, `hash_valid`=0, `busy`=0.
  - `hash_out`=`IV`, `blk_cnt`=0, `err`=0.
  - `cf_rst_n`=0, `b_reg`=0.
- Per block:
  - Cycle 0: accept edge.
  - Cycle 1: LOAD.
  - Cycle 2: first RUN cycle (`CF` released).
  - `cf_done` seen at RUN cycle L; the following edge updates `v_reg`.
  - Throughput is 2+L cycles per block when `blk_valid` is held high.
- Digest:
  - `hash_valid` rises on the edge after `cf_done` of the last block.
  - `blk_ready` returns the cycle after the `hash_ready` handshake.
- All outputs are registered except `busy`, `blk_ready`, and `hash_valid`, which are decoded from the state register only.

## Structure
- Shared package `sm3_pkg`:
  - `SM3_IV` constant.
  - State enum encoding.
  - Block width 512 and digest width 256 constants, also usable by `CF` and the padding front-end.
- Sub-module: exactly one `CF` instance, named `u_cf`.
  - `clk` connects directly.
  - `rst_n` of `u_cf` = `cf_rst_n` & `rst_n`, so a top-level reset forces `u_cf` into reset.
- No other hierarchy.

## Test plan
- **Single block "abc":** send block 61626380_0…0_00000018 with `blk_last`=1. `hash_out` = 66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0 and `blk_cnt`=1.
- **Two blocks:** send "abcd"×16, then 80000000_0…0_00000200 with `blk_last`=1. `hash_out` = debe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732 and `blk_cnt`=2.
- **Backpressure and chaining:**
  - Hold `hash_ready`=0 for 20 cycles; `hash_out` stays stable and `blk_ready` stays 0.
  - Then complete the handshake and send "abc" again; the "abc" digest is reproduced, proving `v_reg` returned to `IV`.
- **Gapped input:** insert 15 idle cycles between blocks of the two-block message. The digest is unchanged.
- **Abort:**
  - Assert `abort` in RUN of block 1 of the two-block message. Expect IDLE, `blk_cnt`=0, `hash_valid` never asserted.
  - Then send "abc"; the correct digest results.
  - Also assert `abort` coincident with `cf_done`; abort wins.
- **Timeout and reset:**
  - Force `cf_done` low. `err`=1 after `TIMEOUT` RUN cycles, then IDLE; `abort` clears `err`.
  - Assert `rst_n` mid-RUN; all outputs return to their reset values asynchronously.
